// File: rtl/haz_pkg.sv
// Shared encodings for the hazard scoreboard: forwarding selects and pipeline-stage countdowns.
package haz_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Countdown value tells which stage currently holds the pending producer.
  localparam logic [1:0] STG_EXE  = 2'd3;
  localparam logic [1:0] STG_MEM  = 2'd2;
  localparam logic [1:0] STG_WB   = 2'd1;
  localparam logic [1:0] STG_NONE = 2'd0;

endpackage

// File: rtl/haz_sb_entry.sv
// One scoreboard entry: pending-write countdown plus load flag.
// A new issue overrides any decrement in the same cycle so the newest producer wins.
module haz_sb_entry
  import haz_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv_i,
  input  logic       issue_i,
  input  logic       iss_ld_i,
  output logic [1:0] cnt_o,
  output logic       ld_o
);

  logic [1:0] cnt_q, cnt_d;
  logic       ld_q, ld_d;

  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (issue_i) begin
      cnt_d = STG_EXE;
      ld_d  = iss_ld_i;
    end else if (adv_i && (cnt_q != STG_NONE)) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_d == STG_NONE) begin
        ld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= STG_NONE;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ld_o  = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit: freeze request and per-source forwarding selects.
// Optional perf counters (freeze_cycles_o, load_use_events_o) under HAZ_PERF_CNT_EN.
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NUM_SRC = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*REG_AW-1:0]   src_addr_i,
  input  logic [NUM_SRC-1:0]          src_valid_i,
  input  logic                        iss_valid_i,
  input  logic                        iss_wb_en_i,
  input  logic                        iss_is_load_i,
  input  logic [REG_AW-1:0]           iss_dest_i,
  input  logic                        flush_i,
  input  logic                        mem_stall_i,
  input  logic                        fwd_en_i,
  output logic                        freeze_o,
  output logic [NUM_SRC*2-1:0]        fwd_sel_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                 freeze_cycles_o,
  output logic [15:0]                 load_use_events_o
`endif
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic                     adv;
  logic                     iss_fire;
  logic [NumRegs-1:0][1:0]  cnt;
  logic [NumRegs-1:0]       ld;
  logic [NUM_SRC-1:0]       hit;

  assign adv      = ~mem_stall_i;
  assign iss_fire = iss_valid_i & iss_wb_en_i & ~flush_i & ~freeze_o & adv;

  for (genvar g = 0; g < NumRegs; g++) begin : g_entry
    haz_sb_entry u_entry (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (adv),
      .issue_i  (iss_fire && (iss_dest_i == REG_AW'(g))),
      .iss_ld_i (iss_is_load_i),
      .cnt_o    (cnt[g]),
      .ld_o     (ld[g])
    );
  end

  always_comb begin
    logic [REG_AW-1:0] addr;
    logic [1:0]        c;
    logic              l;
    logic              act;
    hit       = '0;
    fwd_sel_o = '0;
    addr      = '0;
    c         = STG_NONE;
    l         = 1'b0;
    act       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr = src_addr_i[i*REG_AW +: REG_AW];
      act  = src_valid_i[i] & iss_valid_i;
      c    = cnt[addr];
      l    = ld[addr];
      if (act) begin
        if (fwd_en_i) begin
          // Only a load still in EXE cannot be bypassed.
          if (c == STG_EXE) begin
            if (l) hit[i] = 1'b1;
            else   fwd_sel_o[i*2 +: 2] = FWD_MEM;
          end else if (c == STG_MEM) begin
            fwd_sel_o[i*2 +: 2] = FWD_WB;
          end
        end else begin
          // WB writes before ID reads, so only EXE and MEM producers stall.
          hit[i] = (c >= STG_MEM);
        end
      end
    end
  end

  assign freeze_o = (|hit) & ~flush_i;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] freeze_cycles_q;
  logic [15:0] load_use_events_q;
  logic        freeze_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_cycles_q   <= '0;
      load_use_events_q <= '0;
      freeze_prev_q     <= 1'b0;
    end else begin
      freeze_prev_q <= freeze_o;
      if (freeze_o && adv && (freeze_cycles_q != '1)) begin
        freeze_cycles_q <= freeze_cycles_q + 32'd1;
      end
      if (freeze_o && !freeze_prev_q && fwd_en_i && (load_use_events_q != '1)) begin
        load_use_events_q <= load_use_events_q + 16'd1;
      end
    end
  end

  assign freeze_cycles_o   = freeze_cycles_q;
  assign load_use_events_o = load_use_events_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, async-reset sequence, random vs model.
module tb_hazard_scoreboard;

  localparam int unsigned REG_AW  = 4;
  localparam int unsigned NUM_SRC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] src_addr = '0;
  logic [2:0]  src_valid = '0;
  logic        iss_valid = 1'b0, iss_wb_en = 1'b0, iss_is_load = 1'b0;
  logic [3:0]  iss_dest = '0;
  logic        flush = 1'b0, mem_stall = 1'b0, fwd_en = 1'b0;
  logic        freeze;
  logic [5:0]  fwd_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] freeze_cycles;
  logic [15:0] load_use_events;
`endif

  int total = 0;
  int bad = 0;

  int pend[16];
  bit isld[16];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_addr_i    (src_addr),
    .src_valid_i   (src_valid),
    .iss_valid_i   (iss_valid),
    .iss_wb_en_i   (iss_wb_en),
    .iss_is_load_i (iss_is_load),
    .iss_dest_i    (iss_dest),
    .flush_i       (flush),
    .mem_stall_i   (mem_stall),
    .fwd_en_i      (fwd_en),
    .freeze_o      (freeze),
    .fwd_sel_o     (fwd_sel)
`ifdef HAZ_PERF_CNT_EN
    ,
    .freeze_cycles_o   (freeze_cycles),
    .load_use_events_o (load_use_events)
`endif
  );

  typedef struct {
    logic        iv, wb, ld;
    logic [3:0]  dest;
    logic [11:0] sa;
    logic [2:0]  sv;
    logic        fl, st, fe;
    logic        ef;
    logic [5:0]  es;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, wb, ld, input logic [3:0] dest, input logic [11:0] sa,
                     input logic [2:0] sv, input logic fl, st, fe, ef, input logic [5:0] es);
    vec_t v;
    v.iv = iv; v.wb = wb; v.ld = ld; v.dest = dest; v.sa = sa; v.sv = sv;
    v.fl = fl; v.st = st; v.fe = fe; v.ef = ef; v.es = es;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each register holds "stages left until written back" and a load flag.
  task automatic model_eval(output logic f, output logic [5:0] s);
    int p;
    int a;
    f = 1'b0;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      a = int'(src_addr[i*4 +: 4]);
      p = pend[a];
      if (src_valid[i] && iss_valid) begin
        if (fwd_en) begin
          if (p == 3 && isld[a]) f = 1'b1;
          else if (p == 3) s[i*2 +: 2] = 2'b01;
          else if (p == 2) s[i*2 +: 2] = 2'b10;
        end else if (p >= 2) begin
          f = 1'b1;
        end
      end
    end
    if (flush) f = 1'b0;
  endtask

  task automatic model_step(input logic cur_freeze);
    if (!mem_stall) begin
      for (int r = 0; r < 16; r++) begin
        if (pend[r] > 0) pend[r]--;
        if (pend[r] == 0) isld[r] = 1'b0;
      end
      if (iss_valid && iss_wb_en && !flush && !cur_freeze) begin
        pend[iss_dest] = 3;
        isld[iss_dest] = iss_is_load;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iss_valid = 0; iss_wb_en = 0; iss_is_load = 0; src_valid = '0; flush = 0; mem_stall = 0;
    for (int r = 0; r < 16; r++) begin
      pend[r] = 0;
      isld[r] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic iv, wb, ld, input logic [3:0] dest, input logic [11:0] sa,
                       input logic [2:0] sv, input logic fl, st, fe);
    iss_valid = iv; iss_wb_en = wb; iss_is_load = ld; iss_dest = dest;
    src_addr = sa; src_valid = sv; flush = fl; mem_stall = st; fwd_en = fe;
  endtask

  initial begin
    logic       ef;
    logic [5:0] es;

    // Stall-only ALU producer r3
    add(1,1,0,4'd3, 12'h000,3'b000, 0,0,0, 0,6'b000000);
    add(1,0,0,4'd0, 12'h003,3'b001, 0,0,0, 1,6'b000000);
    add(1,0,0,4'd0, 12'h003,3'b001, 0,0,0, 1,6'b000000);
    add(1,0,0,4'd0, 12'h003,3'b001, 0,0,0, 0,6'b000000);
    // Forwarding ALU producer r5 on src1
    add(1,1,0,4'd5, 12'h000,3'b000, 0,0,1, 0,6'b000000);
    add(1,0,0,4'd0, 12'h050,3'b010, 0,0,1, 0,6'b000100);
    add(1,0,0,4'd0, 12'h050,3'b010, 0,0,1, 0,6'b001000);
    // Load-use on r2
    add(1,1,1,4'd2, 12'h000,3'b000, 0,0,1, 0,6'b000000);
    add(1,0,0,4'd0, 12'h002,3'b001, 0,0,1, 1,6'b000000);
    add(1,0,0,4'd0, 12'h002,3'b001, 0,0,1, 0,6'b000010);
    add(0,0,0,4'd0, 12'h000,3'b000, 0,0,1, 0,6'b000000);
    // Mem stall hold on r4
    add(1,1,0,4'd4, 12'h000,3'b000, 0,0,0, 0,6'b000000);
    for (int k = 0; k < 5; k++) add(1,0,0,4'd0, 12'h004,3'b001, 0,1,0, 1,6'b000000);
    add(1,0,0,4'd0, 12'h004,3'b001, 0,0,0, 1,6'b000000);
    add(1,0,0,4'd0, 12'h004,3'b001, 0,0,0, 1,6'b000000);
    add(1,0,0,4'd0, 12'h004,3'b001, 0,0,0, 0,6'b000000);
    // Flushed write to r7 must not land
    add(1,1,0,4'd7, 12'h007,3'b001, 1,0,0, 0,6'b000000);
    add(1,0,0,4'd0, 12'h007,3'b001, 0,0,0, 0,6'b000000);
    // WAW on r1: ALU then load, newest (load) wins
    add(1,1,0,4'd1, 12'h000,3'b000, 0,0,1, 0,6'b000000);
    add(1,1,1,4'd1, 12'h000,3'b000, 0,0,1, 0,6'b000000);
    add(1,0,0,4'd0, 12'h001,3'b001, 0,0,1, 1,6'b000000);
    add(1,0,0,4'd0, 12'h001,3'b001, 0,0,1, 0,6'b000010);
    // Frozen instruction's write to r9 must not issue; flush masks a live hazard
    add(1,1,0,4'd6, 12'h000,3'b000, 0,0,0, 0,6'b000000);
    add(1,1,0,4'd9, 12'h006,3'b001, 0,0,0, 1,6'b000000);
    add(1,0,0,4'd0, 12'h069,3'b011, 1,0,0, 0,6'b000000);
    add(1,0,0,4'd0, 12'h009,3'b001, 0,0,0, 0,6'b000000);

    do_reset();
    #1;
    check("reset_freeze", {31'd0, freeze}, 32'd0);
    check("reset_fwd_sel", {26'd0, fwd_sel}, 32'd0);

    foreach (vq[k]) begin
      drive(vq[k].iv, vq[k].wb, vq[k].ld, vq[k].dest, vq[k].sa, vq[k].sv,
            vq[k].fl, vq[k].st, vq[k].fe);
      #1;
      check($sformatf("vec%0d_freeze", k), {31'd0, freeze}, {31'd0, vq[k].ef});
      check($sformatf("vec%0d_fwd_sel", k), {26'd0, fwd_sel}, {26'd0, vq[k].es});
      @(negedge clk);
    end

    // Async reset pulse between edges with a live load-use and an ALU forward
    do_reset();
    drive(1,1,0,4'd8, 12'h000,3'b000, 0,0,1);
    @(negedge clk);
    drive(1,1,1,4'd9, 12'h000,3'b000, 0,0,1);
    @(negedge clk);
    drive(1,0,0,4'd0, 12'h098,3'b011, 0,0,1);
    #1;
    check("pre_rst_freeze", {31'd0, freeze}, 32'd1);
    check("pre_rst_fwd_sel", {26'd0, fwd_sel}, 32'h2);
    #1 rst = 1'b1;
    #1;
    check("async_rst_freeze", {31'd0, freeze}, 32'd0);
    check("async_rst_fwd_sel", {26'd0, fwd_sel}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("async_rst_freeze_cycles", freeze_cycles, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_freeze", {31'd0, freeze}, 32'd0);
    check("post_rst_fwd_sel", {26'd0, fwd_sel}, 32'd0);

    // Random traffic against the model, narrow register range to provoke hazards
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            4'($urandom_range(0, 3)),
            {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
            3'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            logic'(n >= 300));
      #1;
      model_eval(ef, es);
      check("rand_freeze", {31'd0, freeze}, {31'd0, ef});
      check("rand_fwd_sel", {26'd0, fwd_sel}, {26'd0, es});
      @(posedge clk);
      model_step(ef);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational freeze logic. It tracks in-flight register writes with a per-register countdown scoreboard instead of comparing against the EXE and MEM destinations.
- Supports N source operands, a runtime forwarding mode, load-use detection and memory-stall holds. It produces a freeze request and per-source forwarding selects.
- Sits beside the ID stage. Its outputs drive the IF/ID hold, the ID/EXE bubble insert and the forwarding muxes, with the selects carried down the ID/EXE register.

Parameters:
- REG_AW, 4, register address width; the scoreboard has 2**REG_AW entries.
- NUM_SRC, 3, number of source operands checked per instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_addr  in  NUM_SRC*REG_AW  packed source register addresses; source i is at bits [i*REG_AW +: REG_AW].
- src_valid  in  NUM_SRC  per-source "operand used" flag; generalises Two_src.
- iss_valid  in  1  instruction present in ID.
- iss_wb_en  in  1  ID instruction writes a register.
- iss_is_load  in  1  ID instruction is a memory load.
- iss_dest  in  REG_AW  ID destination register.
- flush  in  1  ID instruction is squashed this cycle (branch taken).
- mem_stall  in  1  global pipeline hold (SRAM not ready).
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- freeze  out  1  hold IF/ID and insert a bubble into EXE.
- fwd_sel  out  NUM_SRC*2  per-source select: 00 = register file, 01 = MEM-stage result, 10 = WB-stage result; 11 never driven.

Behaviour:
- Scoreboard state:
  - Per entry: cnt[1:0] and ld (load flag).
  - cnt values: 3 = producer in EXE, 2 = MEM, 1 = WB, 0 = no pending write.
- Advance:
  - adv = ~mem_stall.
  - While adv is 0, the scoreboard holds completely.
- Issue:
  - iss_fire = iss_valid & iss_wb_en & ~flush & ~freeze & adv.
  - On iss_fire: entry[iss_dest] <= {cnt=3, ld=iss_is_load}.
- Decrement:
  - When adv is 1, every other entry with cnt != 0 decrements by 1.
  - ld clears when cnt reaches 0.
- Same-cycle conflict: issue to an entry being decremented takes the issue value. The newest producer wins, so WAW collapses to a single entry.
- Per-source check: source i is active when src_valid[i] & iss_valid; c = cnt[src_addr[i]].
- Stall-only mode (fwd_en = 0):
  - hit_i = active & c >= 2. This matches the EXE/MEM compare rule; WB is write-before-read.
  - fwd_sel_i = 00.
- Forwarding mode (fwd_en = 1):
  - hit_i = active & c == 3 & ld (load-use).
  - fwd_sel_i = 01 if active & c == 3 & ~ld; 10 if active & c == 2; otherwise 00.
- Inactive sources: fwd_sel_i = 00 and hit_i = 0.
- freeze = OR of all hit_i, combinational in the same cycle.
- freeze is forced 0 when flush = 1, because the squashed instruction needs no hold.
- freeze and fwd_sel are independent of mem_stall. The top level ORs the hold separately.
- Latency:
  - Outputs are combinational from inputs and current state.
  - State updates on the rising clk edge.
  - A dependent instruction sees the producer one cycle after its issue edge.
- Reset (asynchronous, any time, including mid-stall): all cnt = 0 and ld = 0. freeze therefore reads 0 and all fwd_sel read 00 until the next issue.
- Register 0 receives no special treatment.
- Widths: cnt saturates at 0 and never wraps below it.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds output freeze_cycles [31:0], reset to 0 by rst.
  - Increments on every clk where freeze = 1 and adv = 1.
  - Saturates at 32'hFFFF_FFFF.
  - Adds output load_use_events [15:0], counting rising edges of freeze in forwarding mode; it also saturates.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Package haz_pkg holds:
  - fwd_sel encodings FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
  - Stage constants STG_EXE = 3, STG_MEM = 2, STG_WB = 1, STG_NONE = 0.
- Sub-module haz_sb_entry:
  - One scoreboard entry: cnt/ld registers with issue/decrement priority and asynchronous reset.
  - Instantiated 2**REG_AW times via generate.
- Per-source compare logic stays in the top level.

Test Plan:
- Stall-only, no forwarding: issue ADD r3 (fwd_en = 0); next cycle a consumer with src0 = r3 -> freeze = 1 for 2 cycles (cnt 3, 2), then 0 at cnt = 1; fwd_sel = 00 throughout.
- Forwarding, ALU producer: fwd_en = 1; issue ADD r5; next cycle src1 = r5 -> freeze = 0, fwd_sel[3:2] = 01; with one unrelated instruction between -> 10.
- Load-use: fwd_en = 1; issue LDR r2 (iss_is_load = 1); next cycle src0 = r2 -> freeze = 1 for exactly 1 cycle, then freeze = 0 with fwd_sel[1:0] = 10.
- Mem stall hold: r4 has cnt = 3; assert mem_stall for 5 cycles -> cnt stays 3 and freeze stays 1 for a dependent instruction; after release, 2 further cycles of decrement.
- Flush/WAW: flush = 1 with an iss_valid write to r7 -> entry stays 0 and freeze = 0. Back-to-back writes to r1 -> consumer sees the newest (cnt = 3).
- Async reset mid-pipeline: entries pending; pulse rst between clock edges -> freeze = 0 and fwd_sel = 0 immediately; with HAZ_PERF_CNT_EN, freeze_cycles = 0.
